desc_stream_out: RTL and testbench

//  Consumer of the local_desc descriptor outputs. It captures the 16 x 64-bit cell histograms (tdesc1..16) and the keypoint address

---
 rtl/sift_desc_pkg.sv | 31 +++
 rtl/desc_cell_clip.sv | 21 ++
 rtl/desc_stream_out.sv | 126 ++++++++++++
 tb/tb_desc_stream_out.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sift_desc_pkg.sv
// Shared constants, state encoding and slicing helpers for the SIFT descriptor path.
package sift_desc_pkg;

  localparam int NCELL      = 16;
  localparam int NBIN       = 8;
  localparam int BIN_W      = 8;
  localparam int KP_W       = 18;
  localparam int CELL_W     = NBIN * BIN_W;
  localparam int DESC_W     = NCELL * CELL_W;
  localparam int NBYTE      = NCELL * NBIN;
  localparam int CELL_SUM_W = 11;  // 8 * 255 = 2040
  localparam int SUM_W      = 15;  // 128 * 255 = 32640

  localparam logic [BIN_W-1:0] CLIP_MAX = 8'd51;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLIP   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // Cell idx (0-based) of a flattened descriptor; cell 0 is tdesc1 in the LSBs.
  function automatic logic [CELL_W-1:0] cell_slice(input logic [DESC_W-1:0] desc,
                                                   input logic [3:0]        idx);
    return desc[int'(idx)*CELL_W +: CELL_W];
  endfunction

  // Saturate one bin at CLIP_MAX.
  function automatic logic [BIN_W-1:0] clip_bin(input logic [BIN_W-1:0] b);
    return (b > CLIP_MAX) ? CLIP_MAX : b;
  endfunction

endpackage

// File: rtl/desc_cell_clip.sv
// Combinational clip of the eight bins of one cell plus the sum of the clipped bins.
module desc_cell_clip
  import sift_desc_pkg::*;
(
  input  logic [CELL_W-1:0]     cell_in,
  output logic [CELL_W-1:0]     cell_out,
  output logic [CELL_SUM_W-1:0] cell_sum
);

  // Clip each bin and add the clipped values.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no latch can be inferred.
    cell_out = '0;
    cell_sum = '0;
    for (int b = 0; b < NBIN; b++) begin
      cell_out[b*BIN_W +: BIN_W] = clip_bin(cell_in[b*BIN_W +: BIN_W]);
      cell_sum = cell_sum + CELL_SUM_W'(cell_out[b*BIN_W +: BIN_W]);
    end
  end

endmodule

// File: rtl/desc_stream_out.sv
// Captures a completed descriptor, clips it one cell per cycle, then streams
// the 128 clipped bins as bytes over a valid/ready interface.
module desc_stream_out
  import sift_desc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DESC_W-1:0] desc_in,
  input  logic [KP_W-1:0]   kp_addr_in,
  input  logic              desc_valid,
  output logic              desc_busy,
  output logic              overrun,
  output logic [BIN_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic [KP_W-1:0]   out_kp_addr,
  output logic [SUM_W-1:0]  desc_sum
);

  logic [1:0]        state_q,   state_d;
  logic [DESC_W-1:0] hold_q,    hold_d;
  logic [KP_W-1:0]   kp_q,      kp_d;
  logic [SUM_W-1:0]  acc_q,     acc_d;
  logic [3:0]        cell_q,    cell_d;
  logic [6:0]        byte_q,    byte_d;
  logic              valid_q,   valid_d;
  logic              overrun_q, overrun_d;

  logic [CELL_W-1:0]     cell_clipped;
  logic [CELL_SUM_W-1:0] cell_sum;

  desc_cell_clip u_clip (
    .cell_in  (cell_slice(hold_q, cell_q)),
    .cell_out (cell_clipped),
    .cell_sum (cell_sum)
  );

  // Next-state logic: capture in IDLE, clip a cell per cycle, stream on handshake.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    kp_d      = kp_q;
    acc_d     = acc_q;
    cell_d    = cell_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // A pulse that arrives while a descriptor is held is dropped but remembered.
    if (desc_valid && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (desc_valid) begin
          hold_d  = desc_in;
          kp_d    = kp_addr_in;
          acc_d   = '0;
          cell_d  = '0;
          byte_d  = '0;
          state_d = ST_CLIP;
        end
      end
      ST_CLIP: begin
        hold_d[int'(cell_q)*CELL_W +: CELL_W] = cell_clipped;
        acc_d  = acc_q + SUM_W'(cell_sum);
        cell_d = cell_q + 4'd1;
        if (cell_q == 4'(NCELL - 1)) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // One settle cycle after the last clip before the first byte is offered.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          if (byte_q == 7'(NBYTE - 1)) begin
            valid_d = 1'b0;
            byte_d  = '0;
            state_d = ST_IDLE;
          end else begin
            byte_d = byte_q + 7'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      // NOTE: the holding register is reset so out_data reads 0 after reset; it is a flop bank, not a RAM.
      hold_q    <= '0;
      kp_q      <= '0;
      acc_q     <= '0;
      cell_q    <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      hold_q    <= hold_d;
      kp_q      <= kp_d;
      acc_q     <= acc_d;
      cell_q    <= cell_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Output decode; qualifiers and data are forced low when no byte is offered.
  always_comb begin
    desc_busy   = (state_q != ST_IDLE);
    overrun     = overrun_q;
    out_valid   = valid_q;
    out_data    = valid_q ? hold_q[int'(byte_q)*BIN_W +: BIN_W] : '0;
    out_first   = valid_q && (byte_q == 7'd0);
    out_last    = valid_q && (byte_q == 7'(NBYTE - 1));
    out_kp_addr = kp_q;
    desc_sum    = acc_q;
  end

endmodule

// File: tb/tb_desc_stream_out.sv
// Scoreboard bench for desc_stream_out: stimulus pushes expected bytes, a
// negedge monitor pops and compares on every transfer.
module tb_desc_stream_out;
  import sift_desc_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DESC_W-1:0] desc_in = '0;
  logic [KP_W-1:0]   kp_addr_in = '0;
  logic              desc_valid = 1'b0;
  logic              desc_busy, overrun, out_valid, out_first, out_last;
  logic              out_ready = 1'b1;
  logic [BIN_W-1:0]  out_data;
  logic [KP_W-1:0]   out_kp_addr;
  logic [SUM_W-1:0]  desc_sum;

  desc_stream_out dut (
    .clk(clk), .rst(rst), .desc_in(desc_in), .kp_addr_in(kp_addr_in),
    .desc_valid(desc_valid), .desc_busy(desc_busy), .overrun(overrun),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .out_kp_addr(out_kp_addr),
    .desc_sum(desc_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        first;
    logic        last;
    logic [17:0] kp;
    logic [14:0] sum;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on each transfer, check held byte during a stall.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
      end else if (out_ready) begin
        exp_t e;
        e = sb.pop_front();
        check("data",  32'(out_data),    32'(e.data));
        check("first", 32'(out_first),   32'(e.first));
        check("last",  32'(out_last),    32'(e.last));
        check("kp",    32'(out_kp_addr), 32'(e.kp));
        check("sum",   32'(desc_sum),    32'(e.sum));
      end else begin
        check("stall_data", 32'(out_data), 32'(sb[0].data));
        check("stall_last", 32'(out_last), 32'(sb[0].last));
      end
    end
  end

  function automatic logic [DESC_W-1:0] fill(input logic [7:0] v);
    logic [DESC_W-1:0] d;
    for (int n = 0; n < NBYTE; n++) d[n*8 +: 8] = v;
    return d;
  endfunction

  function automatic logic [DESC_W-1:0] ramp(input int step);
    logic [DESC_W-1:0] d;
    for (int n = 0; n < NBYTE; n++) d[n*8 +: 8] = 8'(n * step);
    return d;
  endfunction

  // Push expected bytes (hand-computed sum) and pulse desc_valid for one edge.
  task automatic send_desc(input logic [DESC_W-1:0] d, input logic [17:0] kp,
                           input logic [14:0] sum);
    exp_t e;
    logic [7:0] b;
    for (int n = 0; n < NBYTE; n++) begin
      b       = d[n*8 +: 8];
      e.data  = (b > 8'd51) ? 8'd51 : b;
      e.first = (n == 0);
      e.last  = (n == NBYTE - 1);
      e.kp    = kp;
      e.sum   = sum;
      sb.push_back(e);
    end
    desc_in    = d;
    kp_addr_in = kp;
    desc_valid = 1'b1;
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  // Drive out_ready (mode 0: always 1; mode 1: 1,0,0 repeating) until the
  // last transfer, optionally poking desc_valid on that edge or resetting
  // after abort_at transfers.
  task automatic run_stream(input int mode, input int abort_at, input bit poke_last);
    int  xfers = 0;
    bit  done  = 0;
    bit  last_x;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      @(negedge clk);
      last_x = out_valid && out_ready && out_last;
      if (out_valid && out_ready) xfers++;
      if (last_x) begin
        check("busy_before_last", 32'(desc_busy), 32'd1);
        if (poke_last) begin
          desc_in    = fill(8'd7);
          kp_addr_in = 18'd1;
          desc_valid = 1'b1;
        end
      end
      @(posedge clk); #1;
      desc_valid = 1'b0;
      if (last_x) begin
        check("busy_fall",  32'(desc_busy), 32'd0);
        check("valid_fall", 32'(out_valid), 32'd0);
        check("xfer_count", 32'(xfers),     32'd128);
        done = 1;
      end else if (abort_at > 0 && xfers == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_valid",   32'(out_valid),   32'd0);
        check("rst_busy",    32'(desc_busy),   32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
        check("rst_data",    32'(out_data),    32'd0);
        check("rst_first",   32'(out_first),   32'd0);
        check("rst_last",    32'(out_last),    32'd0);
        check("rst_kp",      32'(out_kp_addr), 32'd0);
        check("rst_sum",     32'(desc_sum),    32'd0);
        sb.delete();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) check("stream_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_valid",   32'(out_valid),   32'd0);
    check("reset_busy",    32'(desc_busy),   32'd0);
    check("reset_overrun", 32'(overrun),     32'd0);
    check("reset_first",   32'(out_first),   32'd0);
    check("reset_last",    32'(out_last),    32'd0);
    check("reset_sum",     32'(desc_sum),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: all bins 10, latency check
    send_desc(fill(8'd10), 18'd10020, 15'd1280);
    check("t1_busy", 32'(desc_busy), 32'd1);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i == 16) check("t1_valid_k16", 32'(out_valid), 32'd0);
      if (i == 17) begin
        check("t1_valid_k17", 32'(out_valid), 32'd1);
        check("t1_first_k17", 32'(out_first), 32'd1);
      end
    end
    run_stream(0, 0, 0);

    // 2: ramp 0..127
    send_desc(ramp(1), 18'd5, 15'd5202);
    run_stream(0, 0, 0);

    // 3: byte n = 2n, out_ready 1,0,0
    send_desc(ramp(2), 18'd3, 15'd5852);
    run_stream(1, 0, 0);

    // 4: pulses at +5 and at the last-transfer edge are ignored
    send_desc(fill(8'd20), 18'd77, 15'd2560);
    repeat (4) begin @(posedge clk); #1; end
    desc_in    = fill(8'hFF);
    kp_addr_in = 18'd9;
    desc_valid = 1'b1;
    @(posedge clk); #1;
    desc_valid = 1'b0;
    check("t4_overrun", 32'(overrun),   32'd1);
    check("t4_busy",    32'(desc_busy), 32'd1);
    run_stream(0, 0, 1);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);

    // 6 (one cycle after test 4's last edge): all FF
    send_desc(fill(8'hFF), 18'd262143, 15'd6528);
    check("t6_accept", 32'(desc_busy), 32'd1);
    run_stream(0, 0, 0);

    // 5: reset at byte 40, then restart
    send_desc(fill(8'd10), 18'd400, 15'd1280);
    run_stream(0, 40, 0);
    send_desc(ramp(1), 18'd401, 15'd5202);
    run_stream(0, 0, 0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
